// File: rtl/rr_dff_arb_pkg.sv
// Shared types and helpers for the round-robin shared-register arbiter.
// Optional lock mode is enabled in the top with RR_DFF_ARB_LOCK_EN.
package rr_dff_arb_pkg;

    localparam int N_REQ_DEF = 4;
    localparam int WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    // Sized for the largest supported requester count (16).
    function automatic logic [15:0] onehot(input logic [3:0] idx);
        onehot = 16'h0001 << idx;
    endfunction

endpackage

// File: rtl/rr_dff_arbiter_pick.sv
// Combinational round-robin picker: first set req bit at or after ptr,
// found by rotating a doubled request vector and priority-encoding it.
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int IDW   = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDW-1:0]   ptr,
    output logic             any,
    output logic [IDW-1:0]   win
);

    logic [2*N_REQ-1:0] dbl;
    logic [N_REQ-1:0]   rot;
    logic [IDW-1:0]     off;
    logic [IDW:0]       sum;

    always_comb begin
        dbl = {req, req};
        rot = N_REQ'(dbl >> ptr);
        any = |req;
        off = '0;
        // Descending scan so the lowest rotated offset wins.
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot[i]) off = IDW'(i);
        end
        sum = {1'b0, ptr} + {1'b0, off};
        win = (sum >= (IDW+1)'(N_REQ)) ? IDW'(sum - (IDW+1)'(N_REQ)) : sum[IDW-1:0];
    end

endmodule

// File: rtl/rr_dff_arbiter.sv
// Round-robin write scheduler for one shared WIDTH-bit register.
// Define RR_DFF_ARB_LOCK_EN to add the 'lock' port and LOCKED state.
module rr_dff_arbiter
    import rr_dff_arb_pkg::*;
#(
    parameter  int N_REQ = N_REQ_DEF,
    parameter  int WIDTH = WIDTH_DEF,
    localparam int IDW   = $clog2(N_REQ)
) (
    input  logic               CLK,
    input  logic               RST_n,
`ifdef RR_DFF_ARB_LOCK_EN
    input  logic               lock,
`endif
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] wdata,
    output logic [N_REQ-1:0]       gnt,
    output logic [WIDTH-1:0]       Q,
    output logic [IDW-1:0]         owner,
    output logic                   valid
);

    state_t           state;
    logic [IDW-1:0]   ptr;
    logic [IDW-1:0]   pick_ptr;
    logic [IDW-1:0]   pick_w;
    logic [IDW-1:0]   sel;
    logic             any;
    logic             lock_in;
    logic             lock_hold;

    function automatic logic [IDW-1:0] inc(input logic [IDW-1:0] p);
        inc = (p == IDW'(N_REQ - 1)) ? '0 : p + 1'b1;
    endfunction

`ifdef RR_DFF_ARB_LOCK_EN
    assign lock_in   = lock;
    assign lock_hold = (state == LOCKED) && lock && req[owner];
`else
    assign lock_in   = 1'b0;
    assign lock_hold = 1'b0;
`endif

    // ptr is frozen at the owner while locked; on release the search restarts after it.
    assign pick_ptr = (state == LOCKED) ? inc(ptr) : ptr;

    rr_pick #(.N_REQ(N_REQ), .IDW(IDW)) u_pick (
        .req (req),
        .ptr (pick_ptr),
        .any (any),
        .win (pick_w)
    );

    assign sel = lock_hold ? owner : pick_w;

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            Q     <= '0;
            gnt   <= '0;
            owner <= '0;
            valid <= 1'b0;
            ptr   <= '0;
            state <= IDLE;
        end else if (any) begin
            Q     <= wdata[sel*WIDTH +: WIDTH];
            gnt   <= N_REQ'(onehot(4'(sel)));
            owner <= sel;
            valid <= 1'b1;
            if (lock_in) begin
                ptr   <= sel;
                state <= LOCKED;
            end else begin
                ptr   <= inc(sel);
                state <= GRANT;
            end
        end else begin
            gnt   <= '0;
            state <= IDLE;
            if (state == LOCKED) ptr <= inc(ptr);
        end
    end

    a_gnt_onehot: assert property (@(posedge CLK) disable iff (!RST_n) $onehot0(gnt));
    a_state_gnt:  assert property (@(posedge CLK) disable iff (!RST_n)
                                   ((state == IDLE) == (gnt == '0)));

endmodule

// File: tb/tb_rr_dff_arbiter.sv
// Self-checking bench for rr_dff_arbiter (N_REQ=4, WIDTH=8): vector table
// through a scoreboard queue, plus hand sequences for async reset and lock.
module tb_rr_dff_arbiter;

    logic        CLK;
    logic        RST_n;
    logic        lock;
    logic [3:0]  req;
    logic [31:0] wdata;
    logic [3:0]  gnt;
    logic [7:0]  Q;
    logic [1:0]  owner;
    logic        valid;

    typedef struct {
        logic [3:0]  req;
        logic [31:0] wdata;
        logic [3:0]  gnt;
        logic [7:0]  q;
        logic [1:0]  owner;
        logic        valid;
    } vec_t;

    typedef struct {
        logic [3:0] gnt;
        logic [7:0] q;
        logic [1:0] owner;
        logic       valid;
    } exp_t;

    localparam logic [31:0] D    = 32'h13_12_11_10;
    localparam logic [31:0] D3C  = 32'h13_3C_11_10;
    localparam int          NVEC = 15;

    vec_t tbl [NVEC];
    exp_t sb [$];
    int   checks = 0;
    int   errors = 0;

    rr_dff_arbiter #(.N_REQ(4), .WIDTH(8)) dut (
        .CLK   (CLK),
        .RST_n (RST_n),
`ifdef RR_DFF_ARB_LOCK_EN
        .lock  (lock),
`endif
        .req   (req),
        .wdata (wdata),
        .gnt   (gnt),
        .Q     (Q),
        .owner (owner),
        .valid (valid)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        exp_t e;
        @(negedge CLK);
        req   = v.req;
        wdata = v.wdata;
        sb.push_back('{v.gnt, v.q, v.owner, v.valid});
        @(posedge CLK);
        #1;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard empty at vector %0d", idx);
        end else begin
            e = sb.pop_front();
            chk($sformatf("vec%0d gnt", idx), 32'(gnt), 32'(e.gnt));
            chk($sformatf("vec%0d Q", idx), 32'(Q), 32'(e.q));
            chk($sformatf("vec%0d owner", idx), 32'(owner), 32'(e.owner));
            chk($sformatf("vec%0d valid", idx), 32'(valid), 32'(e.valid));
        end
    endtask

    initial begin
        // single requester, idle, wrap/skip, then bring ptr back to 0
        tbl[0]  = '{4'b0100, D3C, 4'b0100, 8'h3C, 2'd2, 1'b1};
        tbl[1]  = '{4'b0000, D3C, 4'b0000, 8'h3C, 2'd2, 1'b1};
        tbl[2]  = '{4'b0101, D,   4'b0001, 8'h10, 2'd0, 1'b1};
        tbl[3]  = '{4'b0101, D,   4'b0100, 8'h12, 2'd2, 1'b1};
        tbl[4]  = '{4'b0000, D,   4'b0000, 8'h12, 2'd2, 1'b1};
        tbl[5]  = '{4'b1000, D,   4'b1000, 8'h13, 2'd3, 1'b1};
        for (int i = 0; i < 8; i++)
            tbl[6+i] = '{4'b1111, D, 4'(1 << (i % 4)), 8'(8'h10 + i % 4), 2'(i % 4), 1'b1};
        tbl[14] = '{4'b0000, D,   4'b0000, 8'h13, 2'd3, 1'b1};

        RST_n = 1'b0;
        lock  = 1'b0;
        req   = 4'b1111;
        wdata = D;
        repeat (5) @(posedge CLK);
        #1;
        chk("reset Q", 32'(Q), 32'h0);
        chk("reset gnt", 32'(gnt), 32'h0);
        chk("reset valid", 32'(valid), 32'h0);
        chk("reset owner", 32'(owner), 32'h0);
        @(negedge CLK);
        req   = 4'b0000;
        RST_n = 1'b1;

        for (int i = 0; i < NVEC; i++) apply(tbl[i], i);

        // async reset between edges while Q holds A5
        @(negedge CLK);
        req   = 4'b0001;
        wdata = 32'h0000_00A5;
        @(posedge CLK);
        #1;
        chk("a5 Q", 32'(Q), 32'hA5);
        req = 4'b0000;
        #2 RST_n = 1'b0;
        #1;
        chk("async rst Q", 32'(Q), 32'h0);
        chk("async rst valid", 32'(valid), 32'h0);
        @(negedge CLK);
        RST_n = 1'b1;

        // reset pulse during a streaming grant
        @(negedge CLK);
        req   = 4'b1111;
        wdata = D;
        @(posedge CLK);
        #1;
        chk("stream gnt0", 32'(gnt), 32'h1);
        @(posedge CLK);
        #1;
        chk("stream gnt1", 32'(gnt), 32'h2);
        #2 RST_n = 1'b0;
        #1;
        chk("midrst gnt", 32'(gnt), 32'h0);
        chk("midrst Q", 32'(Q), 32'h0);
        #1 RST_n = 1'b1;
        @(posedge CLK);
        #1;
        chk("post rst gnt", 32'(gnt), 32'h1);
        chk("post rst Q", 32'(Q), 32'h10);
        chk("post rst owner", 32'(owner), 32'h0);
        @(negedge CLK);
        req = 4'b0000;

`ifdef RR_DFF_ARB_LOCK_EN
        // ptr is 1 here; requester 1 wins with lock held
        @(negedge CLK);
        req  = 4'b1111;
        lock = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge CLK);
            #1;
            chk($sformatf("lock gnt%0d", i), 32'(gnt), 32'h2);
            chk($sformatf("lock Q%0d", i), 32'(Q), 32'h11);
        end
        @(negedge CLK);
        lock = 1'b0;
        @(posedge CLK);
        #1;
        chk("unlock gnt", 32'(gnt), 32'h4);
        chk("unlock Q", 32'(Q), 32'h12);
        @(negedge CLK);
        req = 4'b0000;
`endif

        @(posedge CLK);
        #1;
        chk("final idle gnt", 32'(gnt), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_dff_arbiter.md
Name: rr_dff_arbiter

Overview:
- Shares one WIDTH-bit asynchronous-reset D-register among N_REQ requesters using round-robin arbitration.
- Each cycle it picks at most one requester, loads that requester's data into the shared register, and returns a one-cycle grant as the write acknowledge.
- Sits in front of the basic storage-gate blocks; it is the write scheduler for a shared state register.

Parameters:
N_REQ, 4, number of requesters (2..16)
WIDTH, 8, data width of the shared register
IDW, $clog2(N_REQ), width of the owner index (derived, not overridden)

Ports:
CLK  input  1  clock, rising-edge active
RST_n  input  1  reset, asynchronous, active-low
req  input  N_REQ  per-requester write request, level
wdata  input  N_REQ*WIDTH  packed write data; slice i = wdata[i*WIDTH +: WIDTH]
gnt  output  N_REQ  registered one-hot grant/ack; pulses for one cycle per accepted write
Q  output  WIDTH  shared register contents
owner  output  IDW  index of the last requester written
valid  output  1  high once Q holds at least one written value since reset

Behaviour:
- Reset (RST_n=0, async, takes effect immediately, also mid-cycle and mid-grant): Q=0, gnt=0, owner=0, valid=0, ptr=0, state=IDLE. When RST_n releases, the next rising edge is the first that can grant.
- Internal pointer ptr (IDW bits) gives the highest-priority index. Search order: ptr, ptr+1, ..., wrapping mod N_REQ.
- At a rising edge with req!=0:
  - winner w = first index in search order with req[w]=1.
  - Q<=wdata slice w, gnt<=onehot(w), owner<=w, valid<=1.
  - ptr<=(w+1) mod N_REQ; wrap from N_REQ-1 goes to 0.
- At a rising edge with req==0: gnt<=0. Q, owner, valid and ptr hold.
- Latency: req and data sampled at edge k. Q and gnt are visible after edge k. The requester samples gnt at edge k+1 and must then drop req or present new data.
- A requester that holds req continuously is served again only after every other active requester has been served once. Worst-case wait is N_REQ-1 grants.
- gnt is never multi-hot. gnt=0 in any cycle after a req==0 edge.
- FSM states:
  - IDLE: no grant last edge.
  - GRANT: a grant was issued last edge.
  - Transitions: IDLE->GRANT on req!=0; GRANT->GRANT on req!=0; GRANT->IDLE on req==0.
  - The state is exposed only through gnt!=0. It is used for assertions.
- Data is a straight copy, no arithmetic. The owner index is truncated to IDW bits. Non-power-of-2 N_REQ wraps explicitly at N_REQ-1.

Optional Feature:
- Macro RR_DFF_ARB_LOCK_EN. It adds an input port lock, 1 bit.
- With the macro:
  - If the winner has lock=1 at its grant edge, the FSM enters LOCKED and ptr is frozen at w.
  - While LOCKED, only req[owner] can win. Other requests are ignored.
  - LOCKED->GRANT/IDLE occurs at the first edge where lock=0 or req[owner]=0. Normal round-robin resumes with ptr=owner+1.
  - Reset clears LOCKED.
- Without the macro: there is no lock port, no LOCKED state, and pure round-robin applies.

Decomposition:
- Package rr_dff_arb_pkg:
  - state enum {IDLE, GRANT, LOCKED}
  - default constants N_REQ_DEF=4 and WIDTH_DEF=8
  - a function onehot(idx)
- Sub-module rr_pick (combinational): inputs req and ptr; outputs any and the winner index. It uses a double-width rotate plus a priority encoder.
- The top level holds the ptr, Q, gnt, owner, valid and state registers.

Test Plan:
(All scenarios use N_REQ=4, WIDTH=8.)
1. Reset: hold RST_n=0 for 5 cycles with req=4'b1111 -> Q=8'h00, gnt=0, valid=0. Assert RST_n=0 between clock edges while Q=8'hA5 -> Q=0 immediately, without waiting for a CLK edge.
2. Single requester: req=4'b0100, wdata slice2=8'h3C -> after the next edge Q=8'h3C, gnt=4'b0100, owner=2, valid=1. Drop req -> gnt=0 and Q holds 8'h3C.
3. Round-robin fairness: req=4'b1111 held for 8 edges, slice i data=8'h10+i -> gnt sequence 0001,0010,0100,1000,0001,... and Q sequence 10,11,12,13,10,...
4. Wrap and skip: ptr=3 after granting 2, req=4'b0101 -> grant 0 first (3 is skipped, wrap to 0), then grant 2.
5. Mid-operation reset: req=4'b1111 streaming; pulse RST_n low for 2ns during a grant -> gnt=0 and Q=0 at once. First post-reset grant goes to requester 0.
6. (RR_DFF_ARB_LOCK_EN) Requester 1 wins with lock=1 and req=4'b1111 held -> gnt=4'b0010 for every edge while lock=1. Drop lock -> the next grant goes to 2.
